// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// -----------------
// Issue/operand stage that sits directly in front of the base ALU. It takes
// decoded instruction fields and selects each operand from a register, the
// PC or the immediate. It forwards results still in flight in MEM/WB, then
// captures everything into a single-entry valid/ready register. That
// register drives the ALU's SrcA/SrcB/ALUControl inputs and carries the
// destination tag toward writeback.
//
// Configuration macro: ALU_OPERAND_FWD_EN
//   defined   -> MEM/WB forwarding mux present, hazard tied to 0
//   undefined -> operands taken straight from the register file; the stage
//                stalls (in_ready = 0) while a used source register matches
//                an enabled MEM/WB destination
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         upstream handshake
//   in_rs1_addr, in_rs2_addr    source register indices
//   in_rs1_data, in_rs2_data    register-file read data
//   in_imm, in_pc               immediate and instruction PC
//   in_srca_sel, in_srcb_sel    0 = register, 1 = PC / immediate
//   in_alu_ctrl                 00 ADD, 01 SUB, 10 AND, 11 OR
//   in_rd, in_rd_we             destination tag and write enable
//   mem_rd/mem_we/mem_result    MEM-stage writeback tag, enable, value
//   wb_rd/wb_we/wb_result       WB-stage writeback tag, enable, value
//   flush                       squash held entry and current input
//   out_valid / out_ready       downstream handshake
//   SrcA, SrcB, ALUControl      registered ALU operands and opcode
//   out_rd, out_rd_we           registered destination tag and enable

module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  in_rs1_addr,
  input  logic [RAW-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_srca_sel,
  input  logic            in_srcb_sel,
  input  logic [1:0]      in_alu_ctrl,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_rd_we,
  input  logic [RAW-1:0]  mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RAW-1:0]  wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [1:0]      ALUControl,
  output logic [RAW-1:0]  out_rd,
  output logic            out_rd_we
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] srca_next;
  logic [XLEN-1:0] srcb_next;

  // A source register "matches" an in-flight producer when the producer is
  // writing and the index is nonzero; x0 is hardwired and never forwarded.
  logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;

  assign mem_hit_rs1 = mem_we && (mem_rd == in_rs1_addr) && (in_rs1_addr != '0);
  assign mem_hit_rs2 = mem_we && (mem_rd == in_rs2_addr) && (in_rs2_addr != '0);
  assign wb_hit_rs1  = wb_we  && (wb_rd  == in_rs1_addr) && (in_rs1_addr != '0);
  assign wb_hit_rs2  = wb_we  && (wb_rd  == in_rs2_addr) && (in_rs2_addr != '0);

`ifdef ALU_OPERAND_FWD_EN
  // Forwarding mux: MEM is the younger result, so it wins over WB when both
  // stages target the same register. Forwarding removes every RAW stall.
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    hazard  = 1'b0;
    if (mem_hit_rs1)     rs1_val = mem_result;
    else if (wb_hit_rs1) rs1_val = wb_result;
    if (mem_hit_rs2)     rs2_val = mem_result;
    else if (wb_hit_rs2) rs2_val = wb_result;
  end
`else
  // No forwarding: operands come straight from the register file. Any used
  // source that matches a pending writeback must wait. The hazard is not
  // qualified by in_valid, so in_ready drops even without an instruction.
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    hazard  = (!in_srca_sel && (mem_hit_rs1 || wb_hit_rs1)) ||
              (!in_srcb_sel && (mem_hit_rs2 || wb_hit_rs2));
  end
`endif

  // Operand selection plus the handshake. A new entry may enter when the
  // register is empty or is being drained this cycle. A flush suppresses
  // any capture.
  always_comb begin
    srca_next = in_srca_sel ? in_pc  : rs1_val;
    srcb_next = in_srcb_sel ? in_imm : rs2_val;
    in_ready  = (!out_valid || out_ready) && !hazard;
    capture   = in_valid && in_ready && !flush;
  end

  // Single-entry pipeline register. Flush takes priority and empties it.
  // A capture reloads it, including when the entry drains in the same cycle.
  // Otherwise a drain just drops valid. While stalled, every output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      SrcA       <= '0;
      SrcB       <= '0;
      ALUControl <= 2'b00;
      out_rd     <= '0;
      out_rd_we  <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      SrcA       <= srca_next;
      SrcB       <= srcb_next;
      ALUControl <= in_alu_ctrl;
      out_rd     <= in_rd;
      out_rd_we  <= in_rd_we && (in_rd != '0);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
// --------------------
// Self-checking bench for alu_operand_stage. A behavioural model tracks the
// one-entry output register. Directed cases are followed by a randomized run.
// The model follows ALU_OPERAND_FWD_EN the same way the design does.

module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [RAW-1:0]  in_rs1_addr, in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data;
  logic [XLEN-1:0] in_imm, in_pc;
  logic            in_srca_sel, in_srcb_sel;
  logic [1:0]      in_alu_ctrl;
  logic [RAW-1:0]  in_rd;
  logic            in_rd_we;
  logic [RAW-1:0]  mem_rd, wb_rd;
  logic            mem_we, wb_we;
  logic [XLEN-1:0] mem_result, wb_result;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] SrcA, SrcB;
  logic [1:0]      ALUControl;
  logic [RAW-1:0]  out_rd;
  logic            out_rd_we;

  int checks = 0;
  int errors = 0;

  // Model state: what the output register should hold
  logic            mValid;
  logic [XLEN-1:0] mSrcA, mSrcB;
  logic [1:0]      mCtrl;
  logic [RAW-1:0]  mRd;
  logic            mRdWe;

  // 100 MHz clock
  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_srca_sel(in_srca_sel), .in_srcb_sel(in_srcb_sel),
    .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Value a source register should deliver under the forwarding rules
  function automatic logic [XLEN-1:0] refOperand(input logic [RAW-1:0] rs,
                                                 input logic [XLEN-1:0] rf);
`ifdef ALU_OPERAND_FWD_EN
    if (rs == 0) return rf;
    if (mem_we && mem_rd == rs) return mem_result;
    if (wb_we && wb_rd == rs) return wb_result;
`endif
    return rf;
  endfunction

  // Whether the current inputs should stall the stage (non-forwarding build)
  function automatic bit refHazard();
`ifdef ALU_OPERAND_FWD_EN
    return 1'b0;
`else
    bit a, b;
    a = !in_srca_sel && in_rs1_addr != 0 &&
        ((mem_we && mem_rd == in_rs1_addr) || (wb_we && wb_rd == in_rs1_addr));
    b = !in_srcb_sel && in_rs2_addr != 0 &&
        ((mem_we && mem_rd == in_rs2_addr) || (wb_we && wb_rd == in_rs2_addr));
    return a || b;
`endif
  endfunction

  task automatic modelReset();
    mValid = 0; mSrcA = 0; mSrcB = 0; mCtrl = 0; mRd = 0; mRdWe = 0;
  endtask

  task automatic clearInputs();
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0;
    in_rs2_data = 0; in_imm = 0; in_pc = 0; in_srca_sel = 0; in_srcb_sel = 0;
    in_alu_ctrl = 0; in_rd = 0; in_rd_we = 0; mem_rd = 0; mem_we = 0;
    mem_result = 0; wb_rd = 0; wb_we = 0; wb_result = 0; flush = 0;
    out_ready = 1;
  endtask

  // Runs one clock cycle with the inputs already driven (entered just after
  // a rising edge). Checks in_ready mid-cycle, advances the model across
  // the edge, then checks the registered outputs.
  task automatic applyStimulus();
    bit expReady, cap;
    logic [XLEN-1:0] nA, nB;
    #3;
    expReady = (!mValid || out_ready) && !refHazard();
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
    cap = in_valid && expReady && !flush;
    nA  = in_srca_sel ? in_pc  : refOperand(in_rs1_addr, in_rs1_data);
    nB  = in_srcb_sel ? in_imm : refOperand(in_rs2_addr, in_rs2_data);
    @(posedge clk);
    #1;
    if (flush) mValid = 0;
    else if (cap) begin
      mValid = 1; mSrcA = nA; mSrcB = nB; mCtrl = in_alu_ctrl;
      mRd = in_rd; mRdWe = in_rd_we && (in_rd != 0);
    end else if (out_ready) mValid = 0;
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, mValid});
    if (mValid) begin
      checkOutput("SrcA", SrcA, mSrcA);
      checkOutput("SrcB", SrcB, mSrcB);
      checkOutput("ALUControl", {30'b0, ALUControl}, {30'b0, mCtrl});
      checkOutput("out_rd", {27'b0, out_rd}, {27'b0, mRd});
      checkOutput("out_rd_we", {31'b0, out_rd_we}, {31'b0, mRdWe});
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_srca"}, SrcA, 32'd0);
    checkOutput({tag, "_srcb"}, SrcB, 32'd0);
    checkOutput({tag, "_ctrl"}, {30'b0, ALUControl}, 32'd0);
    checkOutput({tag, "_rd"}, {27'b0, out_rd}, 32'd0);
    checkOutput({tag, "_rdwe"}, {31'b0, out_rd_we}, 32'd0);
    checkOutput({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  // Loads a simple register-register instruction onto the input bus
  task automatic driveInstr(input logic [RAW-1:0] rs1, input logic [XLEN-1:0] d1,
                            input logic [RAW-1:0] rs2, input logic [XLEN-1:0] d2,
                            input logic [1:0] ctrl, input logic [RAW-1:0] rd);
    in_valid = 1; in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2;
    in_rs2_data = d2; in_srca_sel = 0; in_srcb_sel = 0; in_alu_ctrl = ctrl;
    in_rd = rd; in_rd_we = 1;
  endtask

  initial begin
    clearInputs();
    modelReset();
    rst_n = 0;
    #12;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // Plain ADD
    driveInstr(5'd3, 32'd5, 5'd4, 32'd7, 2'b00, 5'd10);
    applyStimulus();
    checkOutput("add_srca", SrcA, 32'd5);
    checkOutput("add_srcb", SrcB, 32'd7);
    checkOutput("add_valid", {31'b0, out_valid}, 32'd1);

    // Destination x0 must never report a write
    driveInstr(5'd1, 32'h11, 5'd2, 32'h22, 2'b11, 5'd0);
    applyStimulus();
    checkOutput("rd0_we", {31'b0, out_rd_we}, 32'd0);

    // Immediate / PC select
    driveInstr(5'd1, 32'h1234, 5'd2, 32'h5678, 2'b00, 5'd5);
    in_srca_sel = 1; in_pc = 32'h100; in_srcb_sel = 1; in_imm = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("pc_srca", SrcA, 32'h100);
    checkOutput("imm_srcb", SrcB, 32'hFFFF_FFFC);
    in_srca_sel = 0; in_srcb_sel = 0;

`ifdef ALU_OPERAND_FWD_EN
    // MEM beats WB on the same register
    driveInstr(5'd6, 32'h55, 5'd7, 32'h66, 2'b01, 5'd8);
    mem_we = 1; mem_rd = 6; mem_result = 32'hAA;
    wb_we = 1; wb_rd = 6; wb_result = 32'hBB;
    applyStimulus();
    checkOutput("fwd_prio", SrcA, 32'hAA);
    // x0 is never forwarded
    driveInstr(5'd0, 32'h77, 5'd7, 32'h66, 2'b01, 5'd8);
    mem_rd = 0; wb_rd = 0;
    applyStimulus();
    checkOutput("fwd_x0", SrcA, 32'h77);
    // WB alone forwards into rs2
    driveInstr(5'd1, 32'h1, 5'd9, 32'h99, 2'b10, 5'd8);
    mem_we = 0; wb_we = 1; wb_rd = 9; wb_result = 32'hCAFE;
    applyStimulus();
    checkOutput("fwd_wb", SrcB, 32'hCAFE);
    mem_we = 0; wb_we = 0;
`else
    // A used rs2 matching a pending WB write stalls until the write clears
    driveInstr(5'd1, 32'h1, 5'd9, 32'h99, 2'b10, 5'd8);
    wb_we = 1; wb_rd = 9; wb_result = 32'hCAFE;
    applyStimulus();
    checkOutput("hazard_ready", {31'b0, in_ready}, 32'd0);
    wb_we = 0;
    applyStimulus();
    checkOutput("hazard_clear", SrcB, 32'h99);
    // An unused source (immediate selected) does not stall
    wb_we = 1; in_srcb_sel = 1; in_imm = 32'h42;
    applyStimulus();
    checkOutput("hazard_unused", SrcB, 32'h42);
    wb_we = 0; in_srcb_sel = 0;
`endif

    // Back-pressure: A captured, held for 3 cycles while B waits, then B
    // loads on the same edge that A drains
    driveInstr(5'd1, 32'hA0A0, 5'd2, 32'hA1A1, 2'b01, 5'd3);
    applyStimulus();
    out_ready = 0;
    driveInstr(5'd1, 32'hB0B0, 5'd2, 32'hB1B1, 2'b10, 5'd4);
    repeat (3) begin
      applyStimulus();
      checkOutput("stall_hold", SrcA, 32'hA0A0);
    end
    out_ready = 1;
    applyStimulus();
    checkOutput("b2b_srca", SrcA, 32'hB0B0);
    checkOutput("b2b_valid", {31'b0, out_valid}, 32'd1);

    // Flush while holding an entry discards both it and the new input
    out_ready = 0;
    driveInstr(5'd5, 32'hC0C0, 5'd6, 32'hC1C1, 2'b11, 5'd7);
    flush = 1;
    applyStimulus();
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 0;

    // Reset asserted mid-stall clears everything immediately
    driveInstr(5'd5, 32'hD0D0, 5'd6, 32'hD1D1, 2'b01, 5'd7);
    applyStimulus();
    applyStimulus();
    #1;
    rst_n = 0;
    #1;
    checkResetOutputs("midreset");
    modelReset();
    @(posedge clk); #1;
    checkResetOutputs("inreset");
    rst_n = 1;
    clearInputs();

    // Randomized traffic with small register indices to provoke matches
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_rs1_addr = RAW'($urandom_range(0, 3));
      in_rs2_addr = RAW'($urandom_range(0, 3));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_pc       = $urandom;
      in_srca_sel = ($urandom_range(0, 3) == 0);
      in_srcb_sel = ($urandom_range(0, 3) == 0);
      in_alu_ctrl = 2'($urandom_range(0, 3));
      in_rd       = RAW'($urandom_range(0, 3));
      in_rd_we    = $urandom_range(0, 1) == 1;
      mem_rd      = RAW'($urandom_range(0, 3));
      mem_we      = ($urandom_range(0, 2) == 0);
      mem_result  = $urandom;
      wb_rd       = RAW'($urandom_range(0, 3));
      wb_we       = ($urandom_range(0, 2) == 0);
      wb_result   = $urandom;
      flush       = ($urandom_range(0, 9) == 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
